// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) transmitter: nibble in over valid/ready, registered codeword out plus LSB-first serial stream.
// Optional error injection on the codeword is compiled in with `define HAM_ERR_INJECT_EN.
module ham_encoder_tx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [3:0] d,
`ifdef HAM_ERR_INJECT_EN
  input  logic [2:0] inj_pos,
`endif
  output logic [6:0] cw,
  output logic       cw_valid,
  output logic       ser_out,
  output logic       ser_en,
  output logic       busy
);

  localparam int CNT_W = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [6:0]       cw_nxt;
  logic             cw_valid_nxt;
  logic [6:0]       enc;
  logic [6:0]       inj_mask;

  // Parity bits sit at Hamming positions 1, 2 and 4 so the syndrome names the flipped position.
  assign enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};

`ifdef HAM_ERR_INJECT_EN
  assign inj_mask = (inj_pos == 3'd0) ? 7'd0 : (7'd1 << (inj_pos - 3'd1));
`else
  assign inj_mask = 7'd0;
`endif

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    cw_nxt       = cw;
    cw_valid_nxt = 1'b0;
    d_ready      = 1'b0;
    busy         = 1'b0;
    ser_en       = 1'b0;
    ser_out      = 1'b0;
    case (state)
      IDLE: begin
        d_ready = 1'b1;
        if (d_valid) begin
          cw_nxt       = enc ^ inj_mask;
          cw_valid_nxt = 1'b1;
          cnt_nxt      = '0;
          bit_idx_nxt  = 3'd0;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = cw[bit_idx];
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd6) begin
            state_nxt = IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      cw       <= 7'd0;
      cw_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      cw       <= cw_nxt;
      cw_valid <= cw_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Scoreboard bench for ham_encoder_tx: lane 0 runs BIT_CYCLES=1, lane 1 runs BIT_CYCLES=3.
module tb_ham_encoder_tx;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] inj;
  } item_t;

`ifdef HAM_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] d_valid = 2'b00;
  logic [3:0] d [2];
  logic [2:0] inj_pos [2];
  logic [1:0] d_ready, cw_valid, ser_out, ser_en, busy;
  logic [6:0] cw [2];

  item_t q0[$];
  item_t q1[$];
  bit    done = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ham_encoder_tx #(.BIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .d_valid  (d_valid[g]),
      .d_ready  (d_ready[g]),
      .d        (d[g]),
`ifdef HAM_ERR_INJECT_EN
      .inj_pos  (inj_pos[g]),
`endif
      .cw       (cw[g]),
      .cw_valid (cw_valid[g]),
      .ser_out  (ser_out[g]),
      .ser_en   (ser_en[g]),
      .busy     (busy[g])
    );
  end

  function automatic int bc(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // Reference: data bits occupy non-power-of-two positions 3,5,6,7; parity at 2^j covers positions with bit j set.
  function automatic logic [6:0] ref_enc(input logic [3:0] dd, input logic [2:0] inj);
    logic [6:0] e;
    int dpos;
    logic par;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      dpos = (i == 0) ? 3 : (i == 1) ? 5 : (i == 2) ? 6 : 7;
      e[dpos-1] = dd[i];
    end
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par ^= e[p-1];
      e[(1 << j) - 1] = par;
    end
    if (inj != 0) e[inj-1] = ~e[inj-1];
    return e;
  endfunction

  function automatic int syndrome(input logic [6:0] e);
    int s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (e[p-1]) s ^= p;
    return s;
  endfunction

  function automatic logic [3:0] corrected(input logic [6:0] e);
    logic [6:0] c;
    int s;
    c = e;
    s = syndrome(e);
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input int l, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s lane%0d: got %0h want %0h at %0t", name, l, got, want, $time);
    end
  endtask

  // Monitor / scoreboard
  int         t [2] = '{0, 0};
  logic       act [2] = '{1'b0, 1'b0};
  logic       rst_seen [2] = '{1'b0, 1'b0};
  logic [6:0] cur [2];

  always @(negedge clk) begin
    item_t it;
    int    qs;
    if (done) begin
      chk("queue0 drained", 0, q0.size(), 0);
      chk("queue1 drained", 1, q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
    for (int l = 0; l < 2; l++) begin
      if (rst_seen[l]) begin
        chk("rst cw", l, cw[l], 0);
        chk("rst cw_valid", l, cw_valid[l], 0);
        chk("rst ser_en", l, ser_en[l], 0);
        chk("rst ser_out", l, ser_out[l], 0);
        chk("rst busy", l, busy[l], 0);
        chk("rst d_ready", l, d_ready[l], 1);
        rst_seen[l] = 1'b0;
      end else begin
        if (cw_valid[l]) begin
          qs = (l == 0) ? q0.size() : q1.size();
          chk("cw_valid expected", l, qs > 0, 1);
          chk("cw_valid not inside frame", l, act[l], 0);
          if (qs > 0) begin
            it = (l == 0) ? q0.pop_front() : q1.pop_front();
            cur[l] = ref_enc(it.d, it.inj);
            chk("cw", l, cw[l], cur[l]);
            chk("decoder syndrome", l, syndrome(cw[l]), it.inj);
            chk("decoder data", l, corrected(cw[l]), it.d);
            act[l] = 1'b1;
            t[l] = 0;
          end
        end
        if (act[l]) begin
          if (t[l] < 7 * bc(l)) begin
            chk("ser_en in frame", l, ser_en[l], 1);
            chk("busy in frame", l, busy[l], 1);
            chk("d_ready in frame", l, d_ready[l], 0);
            chk("ser_out", l, ser_out[l], cur[l][t[l] / bc(l)]);
            chk("cw held", l, cw[l], cur[l]);
            if (t[l] > 0) chk("cw_valid one pulse", l, cw_valid[l], 0);
            t[l]++;
          end else begin
            chk("d_ready after frame", l, d_ready[l], 1);
            chk("ser_en after frame", l, ser_en[l], 0);
            chk("busy after frame", l, busy[l], 0);
            chk("cw retained", l, cw[l], cur[l]);
            act[l] = 1'b0;
          end
        end else if (!cw_valid[l]) begin
          chk("idle ser_en", l, ser_en[l], 0);
          chk("idle d_ready", l, d_ready[l], 1);
        end
      end
      if (rst[l]) begin
        rst_seen[l] = 1'b1;
        act[l] = 1'b0;
        if (l == 0) q0.delete(); else q1.delete();
      end
    end
  end

  // Stimulus
  task automatic send(input int l, input logic [3:0] dd, input logic [2:0] inj);
    logic r;
    int   n;
    item_t it;
    it.d = dd;
    it.inj = INJ ? inj : 3'd0;
    if (l == 0) q0.push_back(it); else q1.push_back(it);
    d[l] = dd;
    inj_pos[l] = inj;
    d_valid[l] = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r) begin
      @(negedge clk);
      r = d_ready[l];
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        $display("FAIL timeout waiting for d_ready lane%0d", l);
        $fatal(1, "timeout");
      end
    end
    d_valid[l] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    d[0] = 4'd0; d[1] = 4'd0;
    inj_pos[0] = 3'd0; inj_pos[1] = 3'd0;
    idle(3);
    rst = 2'b00;
    idle(2);

    send(0, 4'b1011, 3'd0);
    send(1, 4'b0001, 3'd0);
    // Keep d_valid high through lane 1's SHIFT; frame is 21 cycles so no recapture may appear.
    d_valid[1] = 1'b1;
    idle(12);
    d_valid[1] = 1'b0;

    for (int i = 0; i < 16; i++) send(0, 4'(i), 3'd0);
    if (INJ) begin
      send(0, 4'b1011, 3'd3);
      send(0, 4'b1011, 3'd0);
    end

    // Reset while bit 3 is on the line, then a fresh frame must come out whole.
    send(0, 4'b0110, 3'd0);
    idle(3);
    rst[0] = 1'b1;
    idle(1);
    rst[0] = 1'b0;
    idle(1);
    send(0, 4'b1101, 3'd0);

    for (int i = 0; i < 20; i++) begin
      idle($urandom_range(0, 3));
      send(0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, 2));
      send(1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end
    idle(40);
    done = 1'b1;
    idle(5);
    $display("FAIL monitor did not finish");
    $fatal(1, "no finish");
  end

endmodule
